mul_op_queue: RTL and testbench
===============================

Name: mul_op_queue

Overview:
- Operand-issue front end sitting directly upstream of the 16-bit signed sequential multiplier (seqMul).
- Buffers operand pairs arriving on a valid/ready stream in a small FIFO and issues them one at a time to the multiplier.
- Issue uses the multiplier's start-pulse / ready-level protocol; each product is captured and presented on a valid/ready result port.
- Hides the multiplier's start/ready protocol from producers and consumers and allows back-to-back operand bursts.

Parameters:
- W, 16, operand width; product width is 2*W.
- DEPTH, 4, operand FIFO entries (power of two, >=2).
- TIMEOUT, 64, max cycles in WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH).
- in_a  in  W  signed operand A.
- in_b  in  W  signed operand B.
- mul_a  out  W  operand A to multiplier; registered, stable from ISSUE until capture.
- mul_b  out  W  operand B to multiplier; same timing as mul_a.
- mul_start  out  1  one-cycle start pulse to multiplier; registered.
- mul_ready  in  1  multiplier done level.
- mul_out  in  2W  multiplier product.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_prod  out  2W  signed product.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- busy  out  1  state != IDLE or count != 0.

Behaviour:
- Reset values: in_ready=1, mul_a=0, mul_b=0, mul_start=0, res_valid=0, res_prod=0, count=0, busy=0, state=IDLE. FIFO pointers cleared; FIFO contents are don't-care.
- Push: occurs on an edge where in_valid && in_ready. There is no bypass, so a pushed entry is poppable the next cycle.
- Full: in_ready=0 when count==DEPTH; in_valid is ignored in that case.
- Push and pop on the same edge: count unchanged, both pointers advance; wrap-around is modulo DEPTH.
- Rising-edge detect: mul_ready_q is mul_ready registered, reset 0. rdy_rise = mul_ready && !mul_ready_q.
- FSM states IDLE, ISSUE, WAIT, OUT.
- IDLE: if count>0, pop the head into mul_a/mul_b and go to ISSUE.
- ISSUE: mul_start=1 for exactly this one cycle; go to WAIT next edge.
- WAIT: mul_start=0. On an edge with rdy_rise=1, capture mul_out into res_prod, set res_valid=1, go to OUT.
  - A mul_ready level left high from a previous op never triggers capture; only a rising edge does.
- OUT: res_valid stays high and res_prod stays stable until res_ready=1.
  - On the edge with res_valid && res_ready: clear res_valid.
  - If count>0 at that edge, pop and go to ISSUE directly; otherwise go to IDLE.
- Throughput: operand issue to result is multiplier latency + 2 cycles. In-order; exactly one result per accepted pair.
- mul_a/mul_b change only on a pop edge.
- Arithmetic: none performed; res_prod is mul_out verbatim, interpreted as two's complement 2W bits.
- Reset asserted mid-operation: immediate return to reset values. Pending FIFO entries and any in-flight product are discarded. The multiplier shares the same reset at integration.

Optional Feature:
- Macro: MUL_OPQ_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles elapse without rdy_rise, the FSM aborts: res_valid stays 0, the state returns to IDLE (or ISSUE if count>0), and the operand pair is dropped.
  - An extra output port timeout_err (1 bit, reset 0) pulses high for one cycle on the abort edge.
- When undefined: no counter and no timeout_err port; WAIT lasts indefinitely.

Test Plan:
- Single op: push in_a=15, in_b=3 -> one mul_start pulse with mul_a=15, mul_b=3; then res_valid with res_prod=45; mul_start stays low afterwards.
- Signed ops: push (-5,7), (8,-4), (-6,-5) -> results in order 0xFFFFFFDD (-35), 0xFFFFFFE0 (-32), 0x0000001E (30).
- Full FIFO: with res_ready=0, push 6 pairs back-to-back -> 1 pair issued, count reaches 4, in_ready=0; the 6th pair is held off until a pop; all accepted pairs produce results in order.
- Output stall: hold res_ready=0 for 20 cycles after res_valid -> res_prod stable and no new mul_start. Release res_ready -> next mul_start on the following cycle when count>0.
- Reset mid-WAIT: assert reset with 2 entries queued -> count=0, res_valid=0, mul_start=0 immediately. After release, a new op (100,-2) yields -200.
- Timeout (macro defined, mul_ready tied 0, TIMEOUT=64): push one pair -> timeout_err pulses 64 cycles after entering WAIT, no res_valid, FSM returns to IDLE.

Source files
------------

// File: rtl/mul_op_queue.sv
// -----------------------------------------------------------------------------
// mul_op_queue
//   Operand-issue front end for the 16-bit signed sequential multiplier.
//   Operand pairs arrive on a valid/ready stream and are buffered in a small
//   FIFO. Pairs are issued one at a time using the multiplier's start-pulse /
//   ready-level handshake. Each product is returned on a valid/ready result
//   port. Results come back in order, one per accepted pair.
//
// Optional build macro: MUL_OPQ_TIMEOUT_EN
//   When defined, the block aborts an operation after TIMEOUT cycles in WAIT
//   without a multiplier ready edge. The operand pair is dropped and the
//   block pulses timeout_err.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   in_valid    in   operand pair valid
//   in_ready    out  FIFO can accept (count < DEPTH)
//   in_a/in_b   in   signed operands, W bits
//   mul_a/mul_b out  registered operands to the multiplier, held from issue
//                    until capture
//   mul_start   out  registered one-cycle start pulse
//   mul_ready   in   multiplier done level
//   mul_out     in   multiplier product, 2W bits
//   res_valid   out  result available
//   res_ready   in   consumer accepts result
//   res_prod    out  signed product, 2W bits
//   count       out  FIFO occupancy
//   busy        out  FSM not idle or FIFO not empty
//   timeout_err out  one-cycle abort pulse (only with MUL_OPQ_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module mul_op_queue #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [W-1:0]          in_a,
  input  logic signed [W-1:0]          in_b,
  output logic signed [W-1:0]          mul_a,
  output logic signed [W-1:0]          mul_b,
  output logic                         mul_start,
  input  logic                         mul_ready,
  input  logic signed [2*W-1:0]        mul_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [2*W-1:0]        res_prod,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
`ifdef MUL_OPQ_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   mem_a [DEPTH];
  logic signed [W-1:0]   mem_b [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  mul_ready_q;
  logic                  rdy_rise;
  logic signed [W-1:0]   mul_a_q, mul_b_q;
  logic                  mul_start_q;
  logic                  res_valid_q;
  logic signed [2*W-1:0] res_prod_q;
  logic                  push, pop, capture, res_take, not_empty;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < FULL_C);
  assign push      = in_valid && in_ready;
  // A ready level still high from the previous operation must not count as done.
  assign rdy_rise  = mul_ready && !mul_ready_q;

`ifdef MUL_OPQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          abort;
  logic          timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Next-state and handshake decode
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    capture  = 1'b0;
    res_take = 1'b0;
`ifdef MUL_OPQ_TIMEOUT_EN
    abort    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (rdy_rise) begin
          capture = 1'b1;
          state_d = OUT;
        end
`ifdef MUL_OPQ_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          abort = 1'b1;
          if (not_empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
`endif
      end
      OUT: begin
        if (res_ready) begin
          res_take = 1'b1;
          // Chain straight into the next issue when work is queued.
          if (not_empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Operand storage: contents need no reset, pointers and count do.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= in_a;
      mem_b[wr_ptr_q] <= in_b;
    end
  end

  // Control, issue and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mul_ready_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_prod_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mul_ready_q <= mul_ready;
      mul_start_q <= (state_d == ISSUE);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        mul_a_q  <= mem_a[rd_ptr_q];
        mul_b_q  <= mem_b[rd_ptr_q];
      end
      if (capture) begin
        res_prod_q  <= mul_out;
        res_valid_q <= 1'b1;
      end else if (res_take) begin
        res_valid_q <= 1'b0;
      end
    end
  end

`ifdef MUL_OPQ_TIMEOUT_EN
  // WAIT-cycle counter; restarts from zero on every entry into WAIT.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == WAIT && !rdy_rise && !abort) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= abort;
    end
  end

  assign timeout_err = timeout_err_q;
`endif

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_start = mul_start_q;
  assign res_valid = res_valid_q;
  assign res_prod  = res_prod_q;
  assign count     = count_q;
  assign busy      = (state_q != IDLE) || not_empty;

endmodule

// File: tb/tb_mul_op_queue.sv
// -----------------------------------------------------------------------------
// tb_mul_op_queue
//   Directed testbench for mul_op_queue with a behavioural sequential
//   multiplier (fixed latency, ready level stays high until the next start).
// -----------------------------------------------------------------------------
module tb_mul_op_queue;

  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   in_a, in_b;
  logic signed [W-1:0]   mul_a, mul_b;
  logic                  mul_start;
  logic                  mul_ready;
  logic signed [2*W-1:0] mul_out;
  logic                  res_valid;
  logic                  res_ready;
  logic signed [2*W-1:0] res_prod;
  logic [2:0]            count;
  logic                  busy;
`ifdef MUL_OPQ_TIMEOUT_EN
  logic                  timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_op_queue #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_ready (mul_ready),
    .mul_out   (mul_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_prod  (res_prod),
    .count     (count),
    .busy      (busy)
`ifdef MUL_OPQ_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  // Behavioural multiplier: start drops ready, product appears LAT edges later.
  logic signed [W-1:0]   ma_m, mb_m;
  logic signed [2*W-1:0] mout_m;
  logic                  mrdy_m;
  logic                  mul_kill;
  int                    mcnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mrdy_m <= 1'b0;
      mcnt   <= 0;
      mout_m <= '0;
      ma_m   <= '0;
      mb_m   <= '0;
    end else if (mul_start) begin
      mrdy_m <= 1'b0;
      mcnt   <= LAT;
      ma_m   <= mul_a;
      mb_m   <= mul_b;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mrdy_m <= 1'b1;
        mout_m <= ma_m * mb_m;
      end
    end
  end

  assign mul_ready = mrdy_m & ~mul_kill;
  assign mul_out   = mout_m;

  // Event monitors
  int                    starts;
  logic signed [W-1:0]   iss_a[$];
  logic signed [W-1:0]   iss_b[$];
  logic signed [2*W-1:0] res_q[$];

  initial starts = 0;

  always @(posedge clk) begin
    if (!reset) begin
      if (mul_start) begin
        starts <= starts + 1;
        iss_a.push_back(mul_a);
        iss_b.push_back(mul_b);
      end
      if (res_valid && res_ready) res_q.push_back(res_prod);
    end
  end

  function automatic logic signed [2*W-1:0] res_at(input int idx);
    if (idx < res_q.size()) return res_q[idx];
    return 'x;
  endfunction

  // Stimulus helpers (called at a negedge, return at a negedge)
  task automatic push(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    int n;
    n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL push_accept: in_ready stayed %b, expected 1 within 300 cycles", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic wait_results(input int n, output bit ok);
    int k;
    k = 0;
    while (res_q.size() < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    ok = (res_q.size() >= n);
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0; mul_kill = 1'b0;
    in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (mul_a !== 16'sd0) begin errors++; $display("FAIL reset_mul_a: got %0h expected 0", mul_a); end
    checks++; if (mul_b !== 16'sd0) begin errors++; $display("FAIL reset_mul_b: got %0h expected 0", mul_b); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b expected 0", mul_start); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_prod !== 32'sd0) begin errors++; $display("FAIL reset_res_prod: got %0h expected 0", res_prod); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || count !== 3'd0 || mul_start !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b count=%0d start=%b expected 0/0/0", busy, count, mul_start);
    end
  endtask

  task automatic test_single;
    int s0, b0;
    bit ok;
    s0 = starts; b0 = res_q.size();
    res_ready = 1'b1;
    push(16'sd15, 16'sd3);
    in_valid = 1'b0;
    wait_results(b0 + 1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_done: got %0d results expected %0d", res_q.size(), b0 + 1); end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL single_starts: got %0d expected 1", starts - s0); end
    checks++; if (iss_a.size() <= s0 || iss_a[s0] !== 16'sd15 || iss_b[s0] !== 16'sd3) begin
      errors++; $display("FAIL single_operands: got a=%0d b=%0d expected 15 3", mul_a, mul_b);
    end
    checks++; if (res_at(b0) !== 32'sd45) begin errors++; $display("FAIL single_prod: got %0d expected 45", res_at(b0)); end
    repeat (12) @(negedge clk);
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL single_no_restart: got %0d starts expected 1", starts - s0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_signed;
    int s0, b0;
    bit ok;
    s0 = starts; b0 = res_q.size();
    res_ready = 1'b1;
    push(-16'sd5, 16'sd7);
    push(16'sd8, -16'sd4);
    push(-16'sd6, -16'sd5);
    in_valid = 1'b0;
    wait_results(b0 + 3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL signed_done: got %0d results expected %0d", res_q.size(), b0 + 3); end
    checks++; if (res_at(b0) !== 32'hFFFFFFDD) begin errors++; $display("FAIL signed_r0: got %h expected ffffffdd", res_at(b0)); end
    checks++; if (res_at(b0+1) !== 32'hFFFFFFE0) begin errors++; $display("FAIL signed_r1: got %h expected ffffffe0", res_at(b0+1)); end
    checks++; if (res_at(b0+2) !== 32'h0000001E) begin errors++; $display("FAIL signed_r2: got %h expected 0000001e", res_at(b0+2)); end
    checks++; if (starts - s0 !== 3) begin errors++; $display("FAIL signed_starts: got %0d expected 3", starts - s0); end
  endtask

  task automatic test_full;
    int s0, b0;
    bit ok;
    s0 = starts; b0 = res_q.size();
    res_ready = 1'b0;
    push(16'sd1, 16'sd2);
    push(16'sd3, -16'sd4);
    push(-16'sd7, -16'sd8);
    push(16'sd100, 16'sd100);
    push(16'sh8000, 16'sd2);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL full_issued: got %0d expected 1", starts - s0); end
    in_a = 16'sd32767; in_b = 16'sd32767; in_valid = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_held_off: count=%0d in_ready=%b expected 4 0", count, in_ready);
    end
    res_ready = 1'b1;
    push(16'sd32767, 16'sd32767);
    in_valid = 1'b0;
    wait_results(b0 + 6, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_done: got %0d results expected %0d", res_q.size(), b0 + 6); end
    checks++; if (res_at(b0) !== 32'sd2) begin errors++; $display("FAIL full_r0: got %0d expected 2", res_at(b0)); end
    checks++; if (res_at(b0+1) !== -32'sd12) begin errors++; $display("FAIL full_r1: got %0d expected -12", res_at(b0+1)); end
    checks++; if (res_at(b0+2) !== 32'sd56) begin errors++; $display("FAIL full_r2: got %0d expected 56", res_at(b0+2)); end
    checks++; if (res_at(b0+3) !== 32'sd10000) begin errors++; $display("FAIL full_r3: got %0d expected 10000", res_at(b0+3)); end
    checks++; if (res_at(b0+4) !== 32'hFFFF0000) begin errors++; $display("FAIL full_r4: got %h expected ffff0000", res_at(b0+4)); end
    checks++; if (res_at(b0+5) !== 32'h3FFF0001) begin errors++; $display("FAIL full_r5: got %h expected 3fff0001", res_at(b0+5)); end
  endtask

  task automatic test_stall;
    int s0, b0, st, k;
    bit ok, stable;
    logic signed [2*W-1:0] p;
    s0 = starts; b0 = res_q.size();
    res_ready = 1'b0;
    push(16'sd2, 16'sd3);
    push(16'sd4, 16'sd5);
    in_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", res_valid); end
    p = res_prod; st = starts; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_prod !== p || res_valid !== 1'b1 || mul_start !== 1'b0) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable: got stable=%b expected 1", stable); end
    checks++; if (p !== 32'sd6) begin errors++; $display("FAIL stall_prod: got %0d expected 6", p); end
    checks++; if (starts !== st || st - s0 !== 1) begin errors++; $display("FAIL stall_no_start: got %0d starts expected 1", starts - s0); end
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (mul_start !== 1'b1 || mul_a !== 16'sd4 || mul_b !== 16'sd5) begin
      errors++; $display("FAIL stall_reissue: start=%b a=%0d b=%0d expected 1 4 5", mul_start, mul_a, mul_b);
    end
    wait_results(b0 + 2, ok);
    checks++; if (res_at(b0) !== 32'sd6 || res_at(b0+1) !== 32'sd20) begin
      errors++; $display("FAIL stall_results: got %0d %0d expected 6 20", res_at(b0), res_at(b0+1));
    end
  endtask

  task automatic test_reset_mid;
    int s0, b0;
    bit ok;
    res_ready = 1'b1;
    push(16'sd7, 16'sd7);
    push(16'sd8, 16'sd8);
    push(16'sd9, 16'sd9);
    in_valid = 1'b0;
    checks++; if (count !== 3'd2 || mul_start !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rmid_setup: count=%0d start=%b busy=%b expected 2 0 1", count, mul_start, busy);
    end
    #1 reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", count); end
    checks++; if (res_valid !== 1'b0 || mul_start !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs: res_valid=%b start=%b expected 0 0", res_valid, mul_start);
    end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || mul_a !== 16'sd0) begin
      errors++; $display("FAIL rmid_idle: busy=%b in_ready=%b mul_a=%0d expected 0 1 0", busy, in_ready, mul_a);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    s0 = starts; b0 = res_q.size();
    push(16'sd100, -16'sd2);
    in_valid = 1'b0;
    wait_results(b0 + 1, ok);
    checks++; if (res_at(b0) !== 32'hFFFFFF38) begin errors++; $display("FAIL rmid_prod: got %0d expected -200", res_at(b0)); end
    repeat (30) @(negedge clk);
    checks++; if (res_q.size() !== b0 + 1 || starts - s0 !== 1) begin
      errors++; $display("FAIL rmid_no_stale: results=%0d starts=%0d expected 1 1", res_q.size() - b0, starts - s0);
    end
  endtask

`ifdef MUL_OPQ_TIMEOUT_EN
  task automatic test_timeout;
    int b0, k, n;
    b0 = res_q.size();
    mul_kill = 1'b1; res_ready = 1'b1;
    push(16'sd3, 16'sd3);
    in_valid = 1'b0;
    k = 0;
    while (!mul_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    n = 0;
    while (!timeout_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_delay: got %0d expected %0d", n, TIMEOUT + 1); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_after: err=%b res_valid=%b busy=%b expected 0 0 0", timeout_err, res_valid, busy);
    end
    checks++; if (res_q.size() !== b0) begin errors++; $display("FAIL timeout_no_result: got %0d expected 0", res_q.size() - b0); end
    mul_kill = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_full();
    test_stall();
    test_reset_mid();
`ifdef MUL_OPQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
